// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage registers: state encodings and
// control-field bit positions within the control payload.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    localparam int CTRL_W_DEF     = 8;
    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_ZERO      = 3;

endpackage

// File: rtl/pipe_payload_reg.sv
// Load/clear payload register; clear has priority over load so a flush
// always yields a zero payload.
module pipe_payload_reg #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stat_clr
);

    localparam int PW = DATA_W + CTRL_W;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_load;
    logic             w_main_clear;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic [PW-1:0]    w_main_d;
    logic [PW-1:0]    w_main_q;
    logic [PW-1:0]    w_skid_q;

    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Main is cleared whenever the stage drains to EMPTY so the bubble
    // presented downstream carries zero control.
    always_comb begin
        w_state_nxt  = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = {in_data, in_ctrl};
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_d     = w_skid_q;
                        w_main_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = ST_BUSY;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     ({in_data, in_ctrl}),
        .o_q     (w_skid_q)
    );

    assign {out_data, out_ctrl} = w_main_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a two-deep FIFO reference model is
// updated at each edge and a negedge monitor compares every DUT output to it.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stat_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    item_t mq[$];
    int    m_cnt = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .stat_clr  (stat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth two whose accept signal
    // only looks at occupancy before the edge.
    always @(posedge clk or negedge rst_n) begin
        int sz;
        bit rdy;
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            sz  = mq.size();
            rdy = (sz < 2);
            if (stat_clr)
                m_cnt = 0;
            else if (sz > 0 && !out_ready && !flush && m_cnt < CNT_MAX)
                m_cnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_ready && sz > 0) void'(mq.pop_front());
                if (in_valid && rdy) mq.push_back('{d: in_data, c: in_ctrl});
            end
        end
    end

    always @(negedge clk) begin
        item_t head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("in_ready",  {63'd0, in_ready},  {63'd0, mq.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
        chk("out_data",  {32'd0, out_data},  {32'd0, head.d});
        chk("out_ctrl",  {56'd0, out_ctrl},  {56'd0, head.c});
        chk("stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) cyc();
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // single word, one-cycle latency
        drive(1'b1, 32'h0000_1234, 8'h02, 1'b1);
        cyc();
        chk("first_valid", {63'd0, out_valid}, 64'd1);
        chk("first_data", {32'd0, out_data}, 64'h1234);
        chk("first_ctrl", {56'd0, out_ctrl}, 64'h02);
        chk("first_in_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, '0, '0, 1'b1);
        cyc();

        // back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1);
            cyc();
            chk("stream_data", {32'd0, out_data}, 64'(i));
        end
        drive(1'b0, '0, '0, 1'b1);
        cyc();

        // stall with skid capture, then drain
        drive(1'b1, 32'hA, 8'h01, 1'b0);
        cyc();
        drive(1'b1, 32'hB, 8'h02, 1'b0);
        cyc();
        chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) cyc();
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        chk("drain_B", {32'd0, out_data}, 64'hB);
        cyc();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // flush while FULL discards held entries and the new word C
        drive(1'b1, 32'hA, 8'h02, 1'b0);
        cyc();
        drive(1'b1, 32'hB, 8'h02, 1'b0);
        cyc();
        drive(1'b1, 32'hC, 8'h02, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) cyc();

        // counter saturation, then clear while still stalled
        drive(1'b1, 32'hD, 8'h01, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        repeat (20) cyc();
        chk("sat_cnt", {60'd0, stall_cnt}, 64'(CNT_MAX));
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        chk("clr_cnt", {60'd0, stall_cnt}, 64'd0);

        // async reset in FULL, then recovery
        drive(1'b1, 32'hE, 8'h02, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        cyc();
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 32'h55, 8'h01, 1'b1);
        cyc();
        chk("post_rst_data", {32'd0, out_data}, 64'h55);
        drive(1'b0, '0, '0, 1'b1);
        cyc();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, CTRL_W'($urandom), $urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 99) < 3);
            stat_clr = ($urandom_range(0, 99) < 3);
            cyc();
        end
        flush    = 1'b0;
        stat_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
